// File: rtl/fact_accel.sv
// rtl/fact_accel.sv - memory-mapped iterative factorial accelerator (optional irq via FACT_ACCEL_IRQ_EN)
module fact_accel #(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
`ifdef FACT_ACCEL_IRQ_EN
    ,
    output logic              irq
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N_W-1:0]    n_reg;
    logic [N_W-1:0]    cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] result;
    logic              go_reg;
    logic              done;
    logic              err;

    logic is_idle, is_busy, is_fin;
    logic wr_n, wr_go, go_ok, go_err;
    logic n_too_big, cnt_le1;

    // Only the low N_W bits and bit 0 of the write bus carry meaning here.
    logic wd_unused;
    assign wd_unused = ^wd[DATA_W-1:N_W];

    // Register writes are only accepted while IDLE; this is what keeps N and GO stable mid-run.
    assign wr_n      = we && (a == 2'd0) && is_idle;
    assign wr_go     = we && (a == 2'd1) && wd[0] && is_idle;
    assign n_too_big = 32'(n_reg) > 32'(MAX_N);
    assign go_ok     = wr_go && !n_too_big;
    assign go_err    = wr_go && n_too_big;
    assign cnt_le1   = cnt <= N_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: an out-of-range GO never leaves IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go_ok) state_nxt = S_BUSY;
            S_BUSY:  if (cnt_le1) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State decodes used by the datapath
    always_comb begin
        is_idle = 1'b0;
        is_busy = 1'b0;
        is_fin  = 1'b0;
        case (state)
            S_IDLE:  is_idle = 1'b1;
            S_BUSY:  is_busy = 1'b1;
            S_FIN:   is_fin  = 1'b1;
            default: is_idle = 1'b1;
        endcase
    end

    // Datapath: operand, accumulator/counter, result and sticky status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg  <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            go_reg <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (wr_n) n_reg <= wd[N_W-1:0];
            if (wr_go) begin
                done <= 1'b0;
                err  <= 1'b0;
                if (n_too_big) begin
                    err    <= 1'b1;
                    done   <= 1'b1;
                    result <= '0;
                end else begin
                    acc    <= {{(DATA_W-1){1'b0}}, 1'b1};
                    cnt    <= n_reg;
                    go_reg <= 1'b1;
                end
            end
            if (is_busy && !cnt_le1) begin
                acc <= acc * DATA_W'(cnt);
                cnt <= cnt - N_W'(1);
            end
            if (is_fin) begin
                result <= acc;
                done   <= 1'b1;
                go_reg <= 1'b0;
            end
        end
    end

    // Combinational read mux; STATUS is naturally 0 mid-run because GO cleared the flags
    always_comb begin
        rd = '0;
        case (a)
            2'd0: rd = {{(DATA_W-N_W){1'b0}}, n_reg};
            2'd1: rd = {{(DATA_W-1){1'b0}}, go_reg};
            2'd2: rd = {{(DATA_W-2){1'b0}}, err, done};
            2'd3: rd = result;
            default: rd = '0;
        endcase
    end

`ifdef FACT_ACCEL_IRQ_EN
    // Interrupt: set on completion or error GO; cleared by a STATUS read or accepted GO; set wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          irq <= 1'b0;
        else if (is_fin || go_err)         irq <= 1'b1;
        else if ((!we && a == 2'd2) || wr_go) irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_fact_accel.sv
// tb/tb_fact_accel.sv - directed table-driven bench for fact_accel
`timescale 1ns/1ps
module tb_fact_accel;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
`ifdef FACT_ACCEL_IRQ_EN
    logic        irq;
`endif

    fact_accel #(.DATA_W(32), .N_W(4), .MAX_N(12)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd)
`ifdef FACT_ACCEL_IRQ_EN
        ,
        .irq (irq)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  n;
        logic [31:0] res;
        logic [1:0]  st;
        int          edges;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input logic [1:0] addr, input logic [31:0] exp, input string name);
        a = addr;
        #1;
        n_checks++;
        if (rd !== exp) begin
            n_fail++;
            $display("FAIL %s: rd=0x%08h required 0x%08h", name, rd, exp);
        end
    endtask

    task automatic chk_bit(input logic act, input logic exp, input string name);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b required %0b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = '0;
    endtask

    logic [31:0] prev;

    initial begin
        vt[0] = '{n: 4'd5,  res: 32'd120,       st: 2'd1, edges: 6};
        vt[1] = '{n: 4'd0,  res: 32'd1,         st: 2'd1, edges: 2};
        vt[2] = '{n: 4'd1,  res: 32'd1,         st: 2'd1, edges: 2};
        vt[3] = '{n: 4'd12, res: 32'h1C8CFC00,  st: 2'd1, edges: 13};
        vt[4] = '{n: 4'd13, res: 32'd0,         st: 2'd3, edges: 1};
        vt[5] = '{n: 4'd3,  res: 32'd6,         st: 2'd1, edges: 4};
        vt[6] = '{n: 4'd7,  res: 32'd5040,      st: 2'd1, edges: 8};
        vt[7] = '{n: 4'd15, res: 32'd0,         st: 2'd3, edges: 1};
        vt[8] = '{n: 4'd2,  res: 32'd2,         st: 2'd1, edges: 3};

        rst = 1'b0; we = 1'b0; a = 2'd0; wd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) chk(k[1:0], 32'd0, "reset_rd");

        prev = 32'd0;
        for (int i = 0; i < 9; i++) begin
            wr(2'd0, {28'd0, vt[i].n});
            chk(2'd0, {28'd0, vt[i].n}, "n_readback");
            wr(2'd1, 32'd1);
            if (vt[i].st == 2'd3) begin
                chk(2'd2, 32'd3, "err_status");
                chk(2'd3, 32'd0, "err_result");
                chk(2'd1, 32'd0, "err_go");
            end else begin
                chk(2'd2, 32'd0, "busy_status");
                chk(2'd1, 32'd1, "busy_go");
                chk(2'd3, prev, "busy_result_hold");
                for (int e = 1; e < vt[i].edges; e++) begin
                    tick();
                    chk(2'd2, 32'd0, "busy_status");
                end
                tick();
                chk(2'd2, 32'd1, "done_status");
                chk(2'd3, vt[i].res, "result");
                chk(2'd1, 32'd0, "go_cleared");
            end
            prev = vt[i].res;
        end

        // sticky done, ignored GO=0 write, RO writes ignored, N upper bits masked
        repeat (3) tick();
        chk(2'd2, 32'd1, "sticky_done");
        wr(2'd1, 32'd2);
        chk(2'd1, 32'd0, "go_bit0_zero_ignored");
        chk(2'd2, 32'd1, "status_after_go0");
        wr(2'd3, 32'hDEAD_BEEF);
        chk(2'd3, 32'd2, "result_ro");
        wr(2'd2, 32'd0);
        chk(2'd2, 32'd1, "status_ro");
        wr(2'd0, 32'hFFFF_FFF5);
        chk(2'd0, 32'd5, "n_upper_masked");

        // busy protection: writes to N and GO mid-run are dropped
        wr(2'd0, 32'd6);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        chk(2'd0, 32'd6, "busy_n_protect");
        chk(2'd1, 32'd1, "busy_go_reads1");
        chk(2'd3, 32'd2, "busy_prev_result");
        repeat (4) tick();
        chk(2'd2, 32'd0, "busy6_status");
        tick();
        chk(2'd2, 32'd1, "fact6_done");
        chk(2'd3, 32'd720, "fact6_result");
        chk(2'd0, 32'd6, "fact6_n");

        // asynchronous reset mid-computation
        wr(2'd0, 32'd12);
        wr(2'd1, 32'd1);
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) chk(k[1:0], 32'd0, "midrun_reset_rd");
        @(negedge clk);
        rst = 1'b1;
        repeat (15) tick();
        for (int k = 0; k < 4; k++) chk(k[1:0], 32'd0, "post_reset_rd");
        wr(2'd0, 32'd1);
        wr(2'd1, 32'd1);
        tick();
        chk(2'd2, 32'd0, "post_reset_busy");
        tick();
        chk(2'd2, 32'd1, "post_reset_done");
        chk(2'd3, 32'd1, "post_reset_result");

`ifdef FACT_ACCEL_IRQ_EN
        a = 2'd2;
        tick();
        chk_bit(irq, 1'b0, "irq_cleared_by_read");
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        a = 2'd0;
        repeat (3) tick();
        chk_bit(irq, 1'b0, "irq_low_busy");
        tick();
        chk_bit(irq, 1'b1, "irq_on_fin");
        tick();
        chk_bit(irq, 1'b1, "irq_held");
        a = 2'd2;
        tick();
        chk_bit(irq, 1'b0, "irq_status_clear");
        wr(2'd0, 32'd15);
        chk_bit(irq, 1'b0, "irq_before_err_go");
        wr(2'd1, 32'd1);
        chk_bit(irq, 1'b1, "irq_on_err_go");
        a = 2'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fact_accel.md
Name: fact_accel

Overview:
- Memory-mapped iterative factorial accelerator on the data-memory side of the single-cycle MIPS core.
- Sits downstream of the core: consumes `alu_out` (address), `wd_dm` (write data) and `we_dm` (write enable) after the SoC address decoder gates them, and returns read data to the core's `rd_dm` mux.
- Software writes n, pulses GO, polls STATUS, then reads RESULT = n!.

Parameters:
- DATA_W, 32, width of bus data and of the result.
- N_W, 4, width of the n operand register.
- MAX_N, 12, largest n whose factorial fits in DATA_W bits; larger n raises the error flag.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- we  input  1  write strobe, already qualified by the address decoder for this block.
- a  input  2  word select, driven from address bits [3:2].
- wd  input  DATA_W  write data.
- rd  output  DATA_W  read data, combinational from a.

Behaviour:
- Register map by a:
  - 0: N (R/W, low N_W bits, upper bits read 0).
  - 1: GO (R/W bit0).
  - 2: STATUS (RO, bit1 = err, bit0 = done).
  - 3: RESULT (RO).
  - Writes to RO words are ignored.
- Writes take effect on the rising clk edge when we = 1.
- Reset (rst = 0, asynchronous) clears all state: N = 0, GO = 0, done = 0, err = 0, RESULT = 0, acc = 0, cnt = 0, FSM = IDLE. With a = 0..3 after reset, rd = 0.
- FSM states are IDLE, BUSY and FIN.
- IDLE, write GO with wd[0] = 1:
  - done and err clear.
  - If N > MAX_N: err = 1, done = 1, RESULT = 0, GO stays 0, FSM stays IDLE.
  - Otherwise: acc = 1, cnt = N, GO = 1, FSM goes to BUSY.
- A GO write with wd[0] = 0 is ignored.
- BUSY, each cycle:
  - If cnt <= 1, go to FIN.
  - Else acc = acc * cnt, truncated to DATA_W; cnt = cnt - 1.
- FIN: RESULT = acc, done = 1, GO = 0, FSM goes to IDLE.
- Latency: done reads 1 after max(N,1) + 1 rising edges following the GO write edge.
  - N = 0 or N = 1: 2 edges, RESULT = 1.
- While BUSY or FIN:
  - Writes to N and GO are ignored.
  - STATUS reads 0 and RESULT holds the previous result.
  - GO reads 1.
- done and err are sticky until the next accepted GO write or reset.
- Reset asserted mid-computation aborts immediately to the reset state; no partial result is kept.
- Simultaneous GO write and FIN in the same cycle cannot occur, because writes are ignored in FIN.

Optional Feature:
- Macro: FACT_ACCEL_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit, reset 0).
  - irq sets on the FIN edge or on an error-GO edge.
  - irq clears on any read cycle with a = 2 (STATUS), sampled at the rising edge, or on an accepted GO write.
  - If a set and a clear occur in the same cycle, set wins.
- When undefined: no irq port, no irq logic; software polls STATUS.

Test Plan:
- Reset check: assert rst = 0 mid-run, release -> rd = 0 for a = 0..3, FSM IDLE.
- N = 5, then GO = 1 -> STATUS = 0 and GO reads 1 for 5 edges; on the 6th edge STATUS = 0x1, RESULT = 120.
- N = 0, GO = 1 -> STATUS = 0x1 after 2 edges, RESULT = 1; repeat with N = 1 -> RESULT = 1.
- N = 12, GO = 1 -> RESULT = 479001600 (0x1C8CFC00) after 13 edges; then N = 13, GO = 1 -> next edge STATUS = 0x3, RESULT = 0.
- Busy protection: N = 6, GO; while BUSY write N = 3 and GO = 1 -> ignored, RESULT = 720, N reads 6.
- FACT_ACCEL_IRQ_EN: N = 3, GO -> irq = 1 after 4 edges; read STATUS -> irq = 0 next edge; error GO (N = 15) -> irq = 1 next edge.
